// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-side memory path of the single-cycle MIPS core.
package mips_mem_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  // DataMem decodes word addresses DMEM_BASE..DMEM_LAST inclusive
  localparam int DMEM_BASE = 1000;
  localparam int DMEM_LAST = 2005;

  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_forward_match.sv
// Youngest-match search over the queued stores for load forwarding.
module sb_forward_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] adr_arr,
  input  logic [DEPTH-1:0][DW-1:0] data_arr,
  input  logic [DEPTH-1:0]         valid,
  input  logic [PW-1:0]            rd_ptr,
  input  logic [AW-1:0]            cpu_adr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen wins; valid entries are
  // contiguous from rd_ptr, so this is the entry closest to wr_ptr-1.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid[idx] && (adr_arr[idx] == cpu_adr)) begin
        hit  = 1'b1;
        data = data_arr[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and DataMem; drains one store
// per non-load cycle and forwards queued data to loads.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_memread,
  input  logic          cpu_memwrite,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_memread,
  output logic          mem_memwrite,
  input  logic [DW-1:0] mem_rdata,
  output logic          buf_empty
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][AW-1:0] adr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [PW:0]              count;

  logic             full, enq, drain, load;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    off;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  // A simultaneous read+write is treated as a store; the load half is dropped.
  assign full  = (count == FULL_CNT);
  assign load  = cpu_memread & ~cpu_memwrite & ~rst;
  assign enq   = cpu_memwrite & ~full & ~rst;
  assign drain = (count != '0) & ~cpu_memread & ~rst;

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr;
      valid[i] = ({1'b0, off} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + PW'(1);
      if (drain) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[wr_ptr]  <= cpu_adr;
      data_q[wr_ptr] <= cpu_wdata;
    end
  end

  sb_forward_match #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW),
    .PW   (PW)
  ) u_fwd (
    .adr_arr (adr_q),
    .data_arr(data_q),
    .valid   (valid),
    .rd_ptr  (rd_ptr),
    .cpu_adr (cpu_adr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign mem_memwrite = drain;
  assign mem_memread  = load;
  assign mem_adr      = load ? cpu_adr : adr_q[rd_ptr];
  assign mem_wdata    = data_q[rd_ptr];
  assign stall        = cpu_memwrite & full & ~rst;
  assign buf_empty    = rst | (count == '0);
  assign cpu_rdata    = load ? (fwd_hit ? fwd_data : mem_rdata) : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer with a behavioural DataMem.
module tb_store_buffer;
  import mips_mem_pkg::*;

  localparam int DEPTH = SB_DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_adr = '0, cpu_wdata = '0;
  logic        cpu_memread = 1'b0, cpu_memwrite = 1'b0;
  logic [31:0] cpu_rdata, mem_adr, mem_wdata, mem_rdata;
  logic        stall, mem_memread, mem_memwrite, buf_empty;

  int errors = 0;
  int checks = 0;

  sb_entry_t   sb[$];
  logic [31:0] wlog[$];
  bit          exp_acc;

  logic [31:0] dmem  [DMEM_BASE:DMEM_LAST];
  bit          dvalid[DMEM_BASE:DMEM_LAST];

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_rdata(cpu_rdata),
    .stall(stall), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_rdata(mem_rdata), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  function automatic bit in_range(input logic [31:0] a);
    return (a >= DMEM_BASE) && (a <= DMEM_LAST);
  endfunction

  // Unwritten words read back a recognisable address-derived pattern
  function automatic logic [31:0] dm_read(input logic [31:0] a);
    if (!in_range(a)) return 32'h0;
    return dvalid[a] ? dmem[a] : (32'hD000_0000 | a);
  endfunction

  always_comb mem_rdata = dm_read(mem_adr);

  always @(posedge clk) begin
    if (mem_memwrite && in_range(mem_adr)) begin
      dmem[mem_adr]   = mem_wdata;
      dvalid[mem_adr] = 1'b1;
      wlog.push_back(mem_adr);
    end
  end

  // Scoreboard monitor: every non-reset cycle is checked against the model
  always @(negedge clk) begin
    bit          ew, es;
    logic [31:0] er;
    if (!rst) begin
      ew = (sb.size() != 0) && !cpu_memread;
      es = cpu_memwrite && (sb.size() == DEPTH);
      er = 32'h0;
      if (cpu_memread && !cpu_memwrite) begin
        er = dm_read(cpu_adr);
        foreach (sb[i]) if (sb[i].adr == cpu_adr) er = sb[i].data;
      end
      checks++;
      if (mem_memwrite !== ew) begin
        errors++; $display("FAIL mon_memwrite: got %b expected %b", mem_memwrite, ew);
      end
      if (ew) begin
        checks++;
        if (mem_adr !== sb[0].adr || mem_wdata !== sb[0].data) begin
          errors++;
          $display("FAIL mon_drain: got %0d/%h expected %0d/%h", mem_adr, mem_wdata, sb[0].adr, sb[0].data);
        end
      end
      checks++;
      if (stall !== es) begin
        errors++; $display("FAIL mon_stall: got %b expected %b", stall, es);
      end
      checks++;
      if (mem_memread !== (cpu_memread && !cpu_memwrite)) begin
        errors++; $display("FAIL mon_memread: got %b expected %b", mem_memread, cpu_memread && !cpu_memwrite);
      end
      checks++;
      if (cpu_rdata !== er) begin
        errors++; $display("FAIL mon_rdata: got %h expected %h", cpu_rdata, er);
      end
      checks++;
      if (buf_empty !== (sb.size() == 0)) begin
        errors++; $display("FAIL mon_empty: got %b expected %b", buf_empty, sb.size() == 0);
      end
      if (ew) void'(sb.pop_front());
    end
  end

  task automatic set(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    cpu_memwrite = w;
    cpu_memread  = r;
    cpu_adr      = a;
    cpu_wdata    = d;
    exp_acc      = w && (sb.size() < DEPTH) && !rst;
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    sb_entry_t e;
    @(posedge clk);
    if (rst) sb.delete();
    else if (exp_acc) begin
      e.adr  = cpu_adr;
      e.data = cpu_wdata;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    set(w, r, a, d);
    tick();
  endtask

  task automatic drain_all(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (buf_empty) break;
      op(0, 0, 0, 0);
    end
    if (buf_empty) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set(1, 1, 32'd1500, 32'h1234);
    checks++;
    if ({mem_memwrite, mem_memread, stall, buf_empty} !== 4'b0001 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b re=%b st=%b em=%b rd=%h expected 0 0 0 1 0",
               mem_memwrite, mem_memread, stall, buf_empty, cpu_rdata);
    end
    tick();
    op(0, 0, 0, 0);
    rst = 1'b0;
    set(0, 0, 0, 0);
    checks++;
    if (buf_empty !== 1'b1 || stall !== 1'b0 || mem_memwrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got em=%b st=%b we=%b expected 1 0 0", buf_empty, stall, mem_memwrite);
    end
    tick();
  endtask

  task automatic test_single_store();
    op(1, 0, 32'd1004, 32'hA5A5A5A5);
    set(0, 0, 0, 0);
    checks++;
    if (mem_memwrite !== 1'b1 || mem_adr !== 32'd1004) begin
      errors++; $display("FAIL single_drain: got we=%b adr=%0d expected 1 1004", mem_memwrite, mem_adr);
    end
    tick();
    set(0, 0, 0, 0);
    checks++;
    if (buf_empty !== 1'b1 || dm_read(32'd1004) !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL single_mem: got em=%b data=%h expected 1 a5a5a5a5", buf_empty, dm_read(32'd1004));
    end
    tick();
  endtask

  task automatic test_fill();
    bit ok;
    wlog.delete();
    op(1, 0, 32'd1000, 32'hF000);
    set(0, 1, 32'd1000, 0);
    checks++;
    if (mem_memwrite !== 1'b0 || cpu_rdata !== 32'hF000) begin
      errors++; $display("FAIL fill_load: got we=%b rd=%h expected 0 0000f000", mem_memwrite, cpu_rdata);
    end
    tick();
    for (int k = 1; k < 4; k++) op(1, 1, 32'd1000 + k, 32'hF000 + k);
    set(1, 1, 32'd1004, 32'hF004);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL fill_stall_full: got %b expected 1", stall);
    end
    tick();
    set(1, 0, 32'd1004, 32'hF004);
    checks++;
    if (stall !== 1'b1 || mem_memwrite !== 1'b1) begin
      errors++; $display("FAIL fill_no_accept_on_drain: got st=%b we=%b expected 1 1", stall, mem_memwrite);
    end
    tick();
    set(1, 0, 32'd1004, 32'hF004);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL fill_accept: got %b expected 0", stall);
    end
    tick();
    drain_all(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL fill_timeout: got buf_empty=%b expected 1", buf_empty);
    end
    checks++;
    if (wlog.size() != 5) begin
      errors++; $display("FAIL fill_write_count: got %0d expected 5", wlog.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (wlog[k] !== 32'd1000 + k || dm_read(32'd1000 + k) !== 32'hF000 + k) begin
          errors++;
          $display("FAIL fill_order: got %0d/%h expected %0d/%h", wlog[k], dm_read(32'd1000 + k), 1000 + k, 32'hF000 + k);
        end
      end
    end
  endtask

  task automatic test_forward();
    bit ok;
    op(1, 0, 32'd1010, 32'd7);
    op(1, 1, 32'd1010, 32'd9);
    set(0, 1, 32'd1010, 0);
    checks++;
    if (cpu_rdata !== 32'd9 || mem_memwrite !== 1'b0) begin
      errors++; $display("FAIL fwd_youngest: got rd=%h we=%b expected 9 0", cpu_rdata, mem_memwrite);
    end
    tick();
    set(0, 1, 32'd1011, 0);
    checks++;
    if (cpu_rdata !== (32'hD000_0000 | 32'd1011)) begin
      errors++; $display("FAIL fwd_miss: got %h expected %h", cpu_rdata, 32'hD000_0000 | 32'd1011);
    end
    tick();
    drain_all(ok);
    checks++;
    if (!ok || dm_read(32'd1010) !== 32'd9) begin
      errors++; $display("FAIL fwd_final: got ok=%b data=%h expected 1 9", ok, dm_read(32'd1010));
    end
  endtask

  task automatic test_wrap();
    bit ok;
    wlog.delete();
    for (int k = 0; k < 10; k++) begin
      set(1, k[0], 32'd1020 + k, 32'hC0DE_0000 + k);
      for (int t = 0; t < 8 && !exp_acc; t++) begin
        tick();
        set(1, 0, 32'd1020 + k, 32'hC0DE_0000 + k);
      end
      tick();
    end
    drain_all(ok);
    checks++;
    if (!ok || wlog.size() != 10) begin
      errors++; $display("FAIL wrap_count: got ok=%b writes=%0d expected 1 10", ok, wlog.size());
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (dm_read(32'd1020 + k) !== 32'hC0DE_0000 + k || (k < wlog.size() && wlog[k] !== 32'd1020 + k)) begin
        errors++; $display("FAIL wrap_data: addr %0d got %h expected %h", 1020 + k, dm_read(32'd1020 + k), 32'hC0DE_0000 + k);
      end
    end
  endtask

  task automatic test_reset_mid();
    op(1, 0, 32'd1060, 32'd11);
    op(1, 1, 32'd1061, 32'd12);
    op(1, 1, 32'd1062, 32'd13);
    rst = 1'b1;
    set(0, 0, 0, 0);
    checks++;
    if (mem_memwrite !== 1'b0 || buf_empty !== 1'b1) begin
      errors++; $display("FAIL rstmid_during: got we=%b em=%b expected 0 1", mem_memwrite, buf_empty);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) op(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dm_read(32'd1060 + k) !== (32'hD000_0000 | (32'd1060 + k))) begin
        errors++;
        $display("FAIL rstmid_discard: addr %0d got %h expected %h", 1060 + k, dm_read(32'd1060 + k), 32'hD000_0000 | (32'd1060 + k));
      end
    end
  endtask

  task automatic test_illegal();
    bit ok;
    set(1, 1, 32'd1050, 32'd3);
    checks++;
    if (cpu_rdata !== 32'h0 || mem_memread !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL illegal_port: got rd=%h re=%b st=%b expected 0 0 0", cpu_rdata, mem_memread, stall);
    end
    tick();
    drain_all(ok);
    checks++;
    if (!ok || dm_read(32'd1050) !== 32'd3) begin
      errors++; $display("FAIL illegal_store: got ok=%b data=%h expected 1 3", ok, dm_read(32'd1050));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_store();
    test_fill();
    test_forward();
    test_wrap();
    test_reset_mid();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
